// File: rtl/mem_wb_queue.sv
// Writeback queue between the MEM unit and the CDB arbiter: a circular FIFO of
// completed results, presenting the oldest entry as a CDB request.
module mem_wb_queue #(
  parameter int DEPTH        = 4,
  parameter int STALL_THRESH = 1,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [2:0]    in_warp_id,
  input  logic [1:0]    in_scb_id,
  input  logic [4:0]    in_reg_addr,
  input  logic [7:0]    in_mask,
  input  logic [255:0]  in_data,
  input  logic [31:0]   in_instr,
  input  logic          cdb_grant_i,
  output logic          cdb_req_o,
  output logic [2:0]    cdb_warp_id_o,
  output logic [1:0]    cdb_scb_id_o,
  output logic [4:0]    cdb_reg_addr_o,
  output logic [7:0]    cdb_mask_o,
  output logic [255:0]  cdb_data_o,
  output logic [31:0]   cdb_instr_o,
  output logic          stall_o,
  output logic [AW:0]   count_o,
  output logic          overflow_o
);

  typedef struct packed {
    logic [2:0]   warp_id;
    logic [1:0]   scb_id;
    logic [4:0]   reg_addr;
    logic [7:0]   mask;
    logic [255:0] data;
    logic [31:0]  instr;
  } wb_entry_t;

  wb_entry_t       mem [DEPTH];
  wb_entry_t       head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, push, pop;

  assign full = (count == (AW+1)'(DEPTH));
  assign pop  = rst && (count != '0) && cdb_grant_i;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push = rst && in_valid && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
      if (in_valid && !push) overflow_o <= 1'b1;
    end
  end

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{warp_id: in_warp_id, scb_id: in_scb_id, reg_addr: in_reg_addr,
                       mask: in_mask, data: in_data, instr: in_instr};
  end

  assign head           = mem[rd_ptr];
  assign cdb_req_o      = (count != '0);
  assign cdb_warp_id_o  = head.warp_id;
  assign cdb_scb_id_o   = head.scb_id;
  assign cdb_reg_addr_o = head.reg_addr;
  assign cdb_mask_o     = head.mask;
  assign cdb_data_o     = head.data;
  assign cdb_instr_o    = head.instr;
  assign count_o        = count;
  assign stall_o        = ((DEPTH - int'(count)) <= STALL_THRESH);

endmodule

// File: tb/tb_mem_wb_queue.sv
// Randomized + directed bench for mem_wb_queue against a queue-based reference.
module tb_mem_wb_queue;
  localparam int DEPTH = 4;
  localparam int STALL_THRESH = 1;

  typedef struct packed {
    logic [2:0]   warp_id;
    logic [1:0]   scb_id;
    logic [4:0]   reg_addr;
    logic [7:0]   mask;
    logic [255:0] data;
    logic [31:0]  instr;
  } ent_t;

  logic clk = 0, rst = 1;
  logic in_valid = 0, cdb_grant_i = 0;
  ent_t in_e = '0;
  logic cdb_req_o, stall_o, overflow_o;
  logic [2:0] cdb_warp_id_o;
  logic [1:0] cdb_scb_id_o;
  logic [4:0] cdb_reg_addr_o;
  logic [7:0] cdb_mask_o;
  logic [255:0] cdb_data_o;
  logic [31:0] cdb_instr_o;
  logic [2:0] count_o;

  mem_wb_queue #(.DEPTH(DEPTH), .STALL_THRESH(STALL_THRESH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_warp_id(in_e.warp_id), .in_scb_id(in_e.scb_id), .in_reg_addr(in_e.reg_addr),
    .in_mask(in_e.mask), .in_data(in_e.data), .in_instr(in_e.instr),
    .cdb_grant_i(cdb_grant_i), .cdb_req_o(cdb_req_o),
    .cdb_warp_id_o(cdb_warp_id_o), .cdb_scb_id_o(cdb_scb_id_o),
    .cdb_reg_addr_o(cdb_reg_addr_o), .cdb_mask_o(cdb_mask_o),
    .cdb_data_o(cdb_data_o), .cdb_instr_o(cdb_instr_o),
    .stall_o(stall_o), .count_o(count_o), .overflow_o(overflow_o));

  always #5 clk = ~clk;

  ent_t q[$];
  logic ovf_m = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_state();
    chk("req", cdb_req_o, q.size() != 0);
    chk("count", count_o, q.size());
    chk("stall", stall_o, (DEPTH - q.size()) <= STALL_THRESH);
    chk("overflow", overflow_o, ovf_m);
    if (q.size() != 0) begin
      chk("warp", cdb_warp_id_o, q[0].warp_id);
      chk("scb", cdb_scb_id_o, q[0].scb_id);
      chk("reg", cdb_reg_addr_o, q[0].reg_addr);
      chk("mask", cdb_mask_o, q[0].mask);
      chk("data", cdb_data_o, q[0].data);
      chk("instr", cdb_instr_o, q[0].instr);
    end
  endtask

  function automatic ent_t rnd_ent(input logic [4:0] r);
    ent_t e;
    e.warp_id = 3'($urandom);
    e.scb_id = 2'($urandom);
    e.reg_addr = r;
    e.mask = 8'($urandom);
    for (int i = 0; i < 8; i++) e.data[i*32 +: 32] = $urandom;
    e.instr = $urandom;
    return e;
  endfunction

  // One clock: drive on the falling edge, update the model at the rising edge, check just after.
  task automatic cycle(input logic v, input ent_t e, input logic g);
    bit do_pop, do_push;
    @(negedge clk);
    in_valid = v; in_e = e; cdb_grant_i = g;
    @(posedge clk);
    do_pop = (q.size() != 0) && g;
    do_push = v && (q.size() < DEPTH || do_pop);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(e);
    if (v && !do_push) ovf_m = 1;
    #1 check_state();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    #1;
    q.delete(); ovf_m = 0;
    check_state();
    // Inputs must be ignored across an edge while held in reset.
    in_valid = 1; in_e = rnd_ent(5'd31); cdb_grant_i = 1;
    @(posedge clk); #1 check_state();
    @(negedge clk);
    rst = 1; in_valid = 0; cdb_grant_i = 0;
  endtask

  initial begin
    ent_t e;
    #2 rst = 0;
    #1 check_state();
    #10 rst = 1;

    // Single pass, granted immediately.
    e = rnd_ent(5'd5); e.warp_id = 3'd2; e.data[31:0] = 32'hDEAD_BEEF;
    cycle(1, e, 1);
    cycle(0, '0, 1);
    chk("single_drained", count_o, 0);

    // Back-pressure fill and drain.
    for (int r = 1; r <= 4; r++) cycle(1, rnd_ent(5'(r)), 0);
    for (int i = 0; i < 4; i++) cycle(0, '0, 1);

    // Full with simultaneous push and pop, then overflow.
    for (int r = 1; r <= 4; r++) cycle(1, rnd_ent(5'(r)), 0);
    cycle(1, rnd_ent(5'd5), 1);
    chk("full_simul_count", count_o, 4);
    chk("full_simul_ovf", overflow_o, 0);
    cycle(1, rnd_ent(5'd9), 0);
    chk("overflow_set", overflow_o, 1);
    for (int i = 0; i < 5; i++) cycle(0, '0, 1);

    // Random traffic with grant gaps, wrapping the pointers many times.
    for (int i = 0; i < 300; i++)
      cycle(($urandom_range(0, 2) != 0), rnd_ent(5'($urandom)), ($urandom_range(0, 2) == 0));
    chk("overflow_sticky", overflow_o, 1);

    // Mid-operation reset with three queued entries.
    while (q.size() != 0) cycle(0, '0, 1);
    for (int r = 1; r <= 3; r++) cycle(1, rnd_ent(5'(r)), 0);
    do_reset();
    cycle(1, rnd_ent(5'd7), 0);
    chk("post_reset_head", cdb_reg_addr_o, 7);
    for (int i = 0; i < 100; i++)
      cycle($urandom_range(0, 1), rnd_ent(5'($urandom)), $urandom_range(0, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
